// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined WIDTH-bit shifter/rotator with valid/ready streams
`timescale 1ns/1ps
module barrel_shifter_pipe #(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);

   localparam logic [2:0] MODE_SLL = 3'b000;
   localparam logic [2:0] MODE_SRL = 3'b001;
   localparam logic [2:0] MODE_SRA = 3'b010;
   localparam logic [2:0] MODE_ROL = 3'b011;
   localparam logic [2:0] MODE_ROR = 3'b100;

   // Whole pipeline moves together; it only freezes when a finished result is waiting.
   logic advance;
   logic in_err;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;
   assign in_err   = (in_mode > MODE_ROR);

   // One fixed-distance step; sh is a per-stage constant, so each stage is a plain mux.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0] d,
      input logic [2:0]       mode,
      input int unsigned      sh
   );
      logic [WIDTH-1:0] r;
      r = d;
      case (mode)
         MODE_SLL: r = d << sh;
         MODE_SRL: r = d >> sh;
         MODE_SRA: r = WIDTH'($signed(d) >>> sh);
         MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
         MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
         default:  r = d;
      endcase
      return r;
   endfunction

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      logic             v_d;
      logic [WIDTH-1:0] data_d;
      logic [SHW-1:0]   amt_d;
      logic [2:0]       mode_d;
      logic             err_d;

      logic             v_q;
      logic [WIDTH-1:0] data_q;
      logic [SHW-1:0]   amt_q;
      logic [2:0]       mode_q;
      logic             err_q;

      if (k == 0) begin : g_src
         assign v_d    = in_valid;
         assign data_d = in_data;
         assign amt_d  = in_amt;
         assign mode_d = in_mode;
         assign err_d  = in_err;
      end else begin : g_src
         assign v_d    = g_stage[k-1].v_q;
         assign data_d = g_stage[k-1].data_q;
         assign amt_d  = g_stage[k-1].amt_q;
         assign mode_d = g_stage[k-1].mode_q;
         assign err_d  = g_stage[k-1].err_q;
      end

      // Stage k applies the 2^k step when amount bit k is set; illegal modes pass data untouched.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q    <= 1'b0;
            data_q <= '0;
            amt_q  <= '0;
            mode_q <= '0;
            err_q  <= 1'b0;
         end else if (advance) begin
            v_q <= v_d;
            if (v_d) begin
               data_q <= (amt_d[k] && !err_d) ? shift_step(data_d, mode_d, 32'(1) << k) : data_d;
               amt_q  <= amt_d;
               mode_q <= mode_d;
               err_q  <= err_d;
            end
         end
      end
   end

   assign out_valid = g_stage[SHW-1].v_q;
   assign out_data  = g_stage[SHW-1].data_q;
   assign out_err   = g_stage[SHW-1].err_q;

   // The final stage's amount and mode have no further consumer.
   logic unused_tail;
   assign unused_tail = ^{g_stage[SHW-1].amt_q, g_stage[SHW-1].mode_q};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - directed self-checking bench for barrel_shifter_pipe
`timescale 1ns/1ps
module tb_barrel_shifter_pipe;

   localparam int WIDTH = 8;
   localparam int SHW   = 3;

   localparam logic [2:0] SLL = 3'b000;
   localparam logic [2:0] SRL = 3'b001;
   localparam logic [2:0] SRA = 3'b010;
   localparam logic [2:0] ROL = 3'b011;
   localparam logic [2:0] ROR = 3'b100;
   localparam logic [2:0] BAD = 3'b111;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [2:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_err;

   int checks = 0;
   int errors = 0;

   barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m);
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
   endtask

   task automatic check_out(input string tag, input logic [7:0] d, input logic e);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"},  32'(out_data),  32'(d));
      check({tag, "_err"},   32'(out_err),   32'(e));
   endtask

   initial begin
      int idx_in;
      int idx_out;
      int stall_left;
      int iter;
      bit started;
      bit stalling;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_err",   32'(out_err),   32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // SLL 0x01 by 3, latency: visible after the third rising edge counting the acceptance edge
      @(negedge clk);
      drive(8'h01, 3'd3, SLL);
      @(negedge clk); in_valid = 1'b0;
      check("lat_c1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_c2_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check_out("sll_1_3", 8'h08, 1'b0);
      @(negedge clk);
      check("sll_drain_valid", 32'(out_valid), 32'd0);

      // SRL then SRA of 0x90 by 2, back to back
      drive(8'h90, 3'd2, SRL);
      @(negedge clk); drive(8'h90, 3'd2, SRA);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); check_out("srl_90_2", 8'h24, 1'b0);
      @(negedge clk); check_out("sra_90_2", 8'hE4, 1'b0);
      @(negedge clk); check("sr_drain_valid", 32'(out_valid), 32'd0);

      // Rotates, including amount 0
      drive(8'h81, 3'd1, ROL);
      @(negedge clk); drive(8'h03, 3'd1, ROR);
      @(negedge clk); drive(8'hA5, 3'd0, ROR);
      @(negedge clk); in_valid = 1'b0;
      check_out("rol_81_1", 8'h03, 1'b0);
      @(negedge clk); check_out("ror_03_1", 8'h81, 1'b0);
      @(negedge clk); check_out("ror_a5_0", 8'hA5, 1'b0);
      @(negedge clk); check("rot_drain_valid", 32'(out_valid), 32'd0);

      // Illegal mode passes data through with err; a legal beat right behind it is unaffected
      drive(8'h5A, 3'd4, BAD);
      @(negedge clk); drive(8'h5A, 3'd4, SLL);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); check_out("bad_5a_4", 8'h5A, 1'b1);
      @(negedge clk); check_out("sll_5a_4", 8'hA0, 1'b0);
      @(negedge clk); check("bad_drain_valid", 32'(out_valid), 32'd0);

      // Five-beat stream with a six-cycle output stall once the first result appears
      idx_in = 0; idx_out = 0; stall_left = 0; started = 1'b0; iter = 0;
      while (idx_out < 5 && iter < 40) begin
         if (out_valid && !started) begin
            started    = 1'b1;
            stall_left = 6;
         end
         stalling = (stall_left > 0);
         if (stalling) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         if (idx_in < 5) drive(8'h01, 3'(idx_in), SLL);
         else            in_valid = 1'b0;
         #1;
         if (stalling) begin
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data",  32'(out_data),  32'h01);
         end
         if (out_valid && out_ready) begin
            check("stream_data", 32'(out_data), 32'(8'h01 << idx_out));
            check("stream_err",  32'(out_err),  32'd0);
            idx_out++;
         end
         if (in_valid && in_ready) idx_in++;
         @(negedge clk);
         iter++;
      end
      in_valid = 1'b0;
      check("stream_out_count", 32'(idx_out), 32'd5);
      check("stream_in_count",  32'(idx_in),  32'd5);
      check("stream_drain_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset with two beats in flight, one parked at the output
      out_ready = 1'b0;
      drive(8'h01, 3'd1, SLL);
      @(negedge clk); drive(8'h0F, 3'd2, SLL);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); check_out("pre_rst", 8'h02, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_data",  32'(out_data),  32'd0);
      check("async_rst_err",   32'(out_err),   32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale_valid", 32'(out_valid), 32'd0);
      end
      drive(8'h01, 3'd1, ROR);
      @(negedge clk); in_valid = 1'b0;
      check("post_rst_c1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("post_rst_c2_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check_out("post_rst_ror", 8'h80, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
